// File: rtl/alu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the ALU datapath.
// Owns the PC and IR, decodes ALU/memory/register-file controls, resolves branches.
module alu_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0040
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [3:0]  rs1,
   output logic [3:0]  rs2,
   output logic [3:0]  rd,
   output logic [31:0] imm32,
   output logic        aluAltOp,
   output logic [3:0]  func,
   output logic        alu_src_imm,
   input  logic        beqOut,
   input  logic [31:0] alu_result,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_ack,
   output logic        reg_we,
   output logic [1:0]  wb_sel,
   output logic [31:0] pc,
   output logic        halted
);

   localparam logic [3:0] OP_ALUR = 4'b0000;
   localparam logic [3:0] OP_ALUI = 4'b1000;
   localparam logic [3:0] OP_CMPR = 4'b0010;
   localparam logic [3:0] OP_CMPI = 4'b1010;
   localparam logic [3:0] OP_BR   = 4'b0110;
   localparam logic [3:0] OP_LW   = 4'b1001;
   localparam logic [3:0] OP_SW   = 4'b0101;
   localparam logic [3:0] OP_JAL  = 4'b1011;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

   typedef struct packed {
      logic       legal;
      logic       altOp;
      logic       srcImm;
      logic       isBr;
      logic       isLd;
      logic       isSt;
      logic       isJal;
      logic [3:0] func;
   } ctrl_t;

   state_t      state;
   logic [31:0] ir;
   logic [31:0] jalTarget;
   logic [31:0] pcPlus4;
   logic [31:0] brTarget;
   ctrl_t       dec;

   // Datapath controls are pure functions of IR, so they hold from DECODE through WB.
   always_comb begin
      dec      = '0;
      dec.func = ir[27:24];
      case (ir[31:28])
         OP_ALUR: dec.legal = 1'b1;
         OP_ALUI: begin dec.legal = 1'b1; dec.srcImm = 1'b1; end
         OP_CMPR: begin dec.legal = 1'b1; dec.altOp = 1'b1; end
         OP_CMPI: begin dec.legal = 1'b1; dec.altOp = 1'b1; dec.srcImm = 1'b1; end
         OP_BR:   begin dec.legal = 1'b1; dec.altOp = 1'b1; dec.isBr = 1'b1; end
         OP_LW:   begin dec.legal = 1'b1; dec.srcImm = 1'b1; dec.isLd = 1'b1; dec.func = 4'd0; end
         OP_SW:   begin dec.legal = 1'b1; dec.srcImm = 1'b1; dec.isSt = 1'b1; dec.func = 4'd0; end
         OP_JAL:  begin dec.legal = 1'b1; dec.srcImm = 1'b1; dec.isJal = 1'b1; dec.func = 4'd0; end
         default: ;
      endcase
   end

   assign rs1         = ir[19:16];
   assign rs2         = ir[15:12];
   assign rd          = ir[23:20];
   assign imm32       = {{16{ir[15]}}, ir[15:0]};
   assign aluAltOp    = dec.altOp;
   assign func        = dec.func;
   assign alu_src_imm = dec.srcImm;
   assign imem_addr   = pc;
   assign pcPlus4     = pc + 32'd4;
   assign brTarget    = pcPlus4 + {imm32[29:0], 2'b00};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= FETCH;
         pc        <= RESET_PC;
         ir        <= '0;
         jalTarget <= '0;
         imem_req  <= 1'b0;
         dmem_req  <= 1'b0;
         dmem_we   <= 1'b0;
         reg_we    <= 1'b0;
         wb_sel    <= WB_ALU;
         halted    <= 1'b0;
      end else begin
         case (state)
            FETCH: begin
               // An ack only counts once our request is actually visible on the port.
               if (imem_req && imem_ack) begin
                  ir       <= imem_rdata;
                  imem_req <= 1'b0;
                  state    <= DECODE;
               end else begin
                  imem_req <= 1'b1;
               end
            end
            DECODE: begin
               if (!dec.legal) begin
                  halted <= 1'b1;
                  state  <= HALT;
               end else begin
                  state  <= EXEC;
               end
            end
            EXEC: begin
               if (dec.isBr) begin
                  pc       <= beqOut ? brTarget : pcPlus4;
                  imem_req <= 1'b1;
                  state    <= FETCH;
               end else if (dec.isLd || dec.isSt) begin
                  dmem_req <= 1'b1;
                  dmem_we  <= dec.isSt;
                  state    <= MEM;
               end else begin
                  jalTarget <= alu_result;
                  reg_we    <= 1'b1;
                  wb_sel    <= dec.isJal ? WB_PC4 : WB_ALU;
                  state     <= WB;
               end
            end
            MEM: begin
               if (dmem_ack) begin
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  if (dec.isLd) begin
                     reg_we <= 1'b1;
                     wb_sel <= WB_MEM;
                     state  <= WB;
                  end else begin
                     pc       <= pcPlus4;
                     imem_req <= 1'b1;
                     state    <= FETCH;
                  end
               end
            end
            WB: begin
               reg_we   <= 1'b0;
               pc       <= dec.isJal ? jalTarget : pcPlus4;
               imem_req <= 1'b1;
               state    <= FETCH;
            end
            HALT: begin
               imem_req <= 1'b0;
               dmem_req <= 1'b0;
               dmem_we  <= 1'b0;
               reg_we   <= 1'b0;
               halted   <= 1'b1;
            end
            default: begin
               halted <= 1'b1;
               state  <= HALT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed plus randomized bench for alu_sequencer against an instruction-level model.
module tb_alu_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [3:0]  rs1, rs2, rd;
   logic [31:0] imm32;
   logic        aluAltOp;
   logic [3:0]  func;
   logic        alu_src_imm;
   logic        beqOut;
   logic [31:0] alu_result;
   logic        dmem_req, dmem_we, dmem_ack;
   logic        reg_we;
   logic [1:0]  wb_sel;
   logic [31:0] pc;
   logic        halted;

   int tests = 0;
   int fails = 0;
   logic [31:0] mPc;

   alu_sequencer #(.RESET_PC(32'h0000_0040)) dut (
      .clk(clk), .reset_n(reset_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .rs1(rs1), .rs2(rs2), .rd(rd), .imm32(imm32),
      .aluAltOp(aluAltOp), .func(func), .alu_src_imm(alu_src_imm),
      .beqOut(beqOut), .alu_result(alu_result),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
      .reg_we(reg_we), .wb_sel(wb_sel), .pc(pc), .halted(halted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ISA-level reference: what each opcode means, independent of how the FSM is built.
   function automatic bit isLegal(input logic [3:0] op);
      return op inside {4'h0, 4'h8, 4'h2, 4'hA, 4'h6, 4'h9, 4'h5, 4'hB};
   endfunction
   function automatic logic [31:0] sext(input logic [31:0] i);
      return {{16{i[15]}}, i[15:0]};
   endfunction
   function automatic logic [31:0] nextPc(input logic [31:0] i, input logic [31:0] p,
                                          input bit beq, input logic [31:0] ar);
      if (i[31:28] == 4'h6) return beq ? (p + 32'd4 + sext(i) * 32'd4) : (p + 32'd4);
      if (i[31:28] == 4'hB) return ar;
      return p + 32'd4;
   endfunction
   function automatic int baseLat(input logic [3:0] op);
      case (op)
         4'h6: return 3;
         4'h9: return 5;
         default: return 4;
      endcase
   endfunction
   function automatic bit writesReg(input logic [3:0] op);
      return op inside {4'h0, 4'h8, 4'h2, 4'hA, 4'h9, 4'hB};
   endfunction
   function automatic logic [1:0] wbSrc(input logic [3:0] op);
      return (op == 4'h9) ? 2'd1 : (op == 4'hB) ? 2'd2 : 2'd0;
   endfunction

   task automatic checkCtrl(input logic [31:0] i);
      logic [3:0] op;
      op = i[31:28];
      chk("aluAltOp", aluAltOp, op inside {4'h2, 4'hA, 4'h6});
      chk("alu_src_imm", alu_src_imm, op inside {4'h8, 4'hA, 4'h9, 4'h5, 4'hB});
      chk("func", func, (op inside {4'h9, 4'h5, 4'hB}) ? 4'h0 : i[27:24]);
      chk("rs1", rs1, i[19:16]);
      chk("rs2", rs2, i[15:12]);
      chk("rd", rd, i[23:20]);
      chk("imm32", imm32, sext(i));
   endtask

   task automatic doReset();
      reset_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
      beqOut = 1'b0; alu_result = '0; imem_rdata = '0;
      repeat (2) @(negedge clk);
      mPc = 32'h40;
      reset_n = 1'b1;
   endtask

   task automatic runInstr(input logic [31:0] instr, input int iw, input int dw,
                           input bit beq, input logic [31:0] aluRes);
      logic [3:0] op;
      int n, lat, weCnt, memCnt;
      logic [1:0] wbSeen;
      bit done;
      op = instr[31:28];
      n = 0;
      while (!imem_req && n < 10) begin @(negedge clk); n++; end
      chk("fetchReq", imem_req, 1'b1);
      chk("fetchAddr", imem_addr, mPc);
      for (int i = 0; i <= iw; i++) begin
         if (i > 0) begin
            @(negedge clk);
            chk("fetchHold", imem_req, 1'b1);
            chk("fetchAddrHold", imem_addr, mPc);
         end
         imem_ack = (i == iw);
         imem_rdata = (i == iw) ? instr : $urandom;
      end
      @(negedge clk);
      imem_ack = 1'b0; imem_rdata = $urandom;
      beqOut = 1'($urandom); alu_result = $urandom;
      lat = iw + 2;
      if (!isLegal(op)) begin
         @(negedge clk);
         chk("haltedFlag", halted, 1'b1);
         chk("haltNoReq", imem_req, 1'b0);
         return;
      end
      checkCtrl(instr);
      done = 0; weCnt = 0; memCnt = 0; wbSeen = 2'd3;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (imem_req) begin done = 1; break; end
         lat++;
         checkCtrl(instr);
         beqOut = (k == 0) ? beq : 1'($urandom);
         alu_result = (k == 0) ? aluRes : $urandom;
         imem_ack = 1'($urandom);
         if (reg_we) begin
            weCnt++; wbSeen = wb_sel;
            chk("pcAtWb", pc, mPc);
         end
         if (dmem_req) begin
            chk("dmemWe", dmem_we, op == 4'h5);
            dmem_ack = (memCnt == dw);
            memCnt++;
         end else begin
            dmem_ack = 1'($urandom);
         end
      end
      imem_ack = 1'b0; dmem_ack = 1'b0;
      chk("completed", done, 1'b1);
      chk("latency", lat, baseLat(op) + iw + ((op inside {4'h9, 4'h5}) ? dw : 0));
      chk("regWeCount", weCnt, writesReg(op) ? 1 : 0);
      if (writesReg(op)) chk("wbSel", wbSeen, wbSrc(op));
      chk("dmemReqCycles", memCnt, (op inside {4'h9, 4'h5}) ? dw + 1 : 0);
      mPc = nextPc(instr, mPc, beq, aluRes);
      chk("nextFetchAddr", imem_addr, mPc);
      chk("pcOut", pc, mPc);
   endtask

   initial begin
      logic [3:0] ops [8];
      logic [31:0] r, instr;
      ops = '{4'h0, 4'h8, 4'h2, 4'hA, 4'h6, 4'h9, 4'h5, 4'hB};

      // Reset values
      reset_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
      beqOut = 1'b0; alu_result = '0; imem_rdata = '0;
      repeat (2) @(negedge clk);
      chk("rstImemReq", imem_req, 1'b0);
      chk("rstDmemReq", dmem_req, 1'b0);
      chk("rstDmemWe", dmem_we, 1'b0);
      chk("rstRegWe", reg_we, 1'b0);
      chk("rstHalted", halted, 1'b0);
      chk("rstAltOp", aluAltOp, 1'b0);
      chk("rstSrcImm", alu_src_imm, 1'b0);
      chk("rstFunc", func, 4'h0);
      chk("rstWbSel", wb_sel, 2'd0);
      chk("rstPc", pc, 32'h40);
      mPc = 32'h40;
      reset_n = 1'b1;
      @(negedge clk);
      chk("firstReq", imem_req, 1'b1);
      chk("firstAddr", imem_addr, 32'h40);

      // ALU-R add, then branches and jumps
      runInstr(32'h0031_2000, 0, 0, 0, 32'h0);
      chk("pcAfterAdd", mPc, 32'h44);
      runInstr(32'hB000_0000, 0, 0, 0, 32'h100);
      runInstr(32'h6100_FFFF, 0, 0, 1, 32'h0);
      chk("brTaken", imem_addr, 32'h100);
      runInstr(32'h6100_FFFF, 1, 0, 0, 32'h0);
      chk("brNotTaken", imem_addr, 32'h104);
      runInstr(32'hB000_0000, 0, 0, 0, 32'h200);
      runInstr(32'hB0F0_0010, 0, 0, 0, 32'h300);
      chk("jalTarget", imem_addr, 32'h300);
      runInstr(32'h9052_0008, 0, 3, 0, 32'h0);
      runInstr(32'h5031_FFF0, 2, 1, 0, 32'h0);

      // PC wrap-around
      runInstr(32'hB000_0000, 0, 0, 0, 32'hFFFF_FFFC);
      runInstr(32'h8012_0001, 0, 0, 0, 32'h0);
      chk("pcWrap", imem_addr, 32'h0);

      // Randomized instruction stream
      for (int t = 0; t < 40; t++) begin
         r = $urandom;
         instr = {ops[$urandom_range(7)], r[27:0]};
         runInstr(instr, $urandom_range(2), $urandom_range(2), 1'($urandom), $urandom);
      end

      // Reset in the middle of a store
      runInstr(32'h0000_0000, 0, 0, 0, 32'h0);
      chk("preSwReq", imem_req, 1'b1);
      imem_ack = 1'b1; imem_rdata = 32'h5012_0004;
      @(negedge clk); imem_ack = 1'b0;
      repeat (2) @(negedge clk);
      chk("swMemReq", dmem_req, 1'b1);
      chk("swMemWe", dmem_we, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      chk("rstMidMemReq", dmem_req, 1'b0);
      chk("rstMidMemPc", pc, 32'h40);
      chk("rstMidMemWe", reg_we, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      mPc = 32'h40;

      // Illegal opcode halts until reset
      runInstr(32'hF000_0000, 0, 0, 0, 32'h0);
      for (int k = 0; k < 5; k++) begin
         imem_ack = 1'($urandom);
         @(negedge clk);
         chk("haltHoldReq", imem_req, 1'b0);
         chk("haltHoldFlag", halted, 1'b1);
      end
      doReset();
      @(negedge clk);
      chk("restartReq", imem_req, 1'b1);
      chk("restartAddr", imem_addr, 32'h40);
      chk("restartHalted", halted, 1'b0);
      runInstr(32'h2100_3000, 0, 0, 0, 32'h0);
      chk("restartNext", imem_addr, 32'h44);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
